// File: rtl/dp_acc.sv
// rtl/dp_acc.sv - sequential FP32 accumulator for dot-product chunk results
module dp_acc #(
  parameter int          LEN_W = 16,
  parameter logic [31:0] CNAN  = 32'h7FC0_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [31:0]      r_out_z;
  logic             r_busy;

  logic             w_hs;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [31:0]      w_sum;

  // Single-cycle binary32 add: FTZ inputs/outputs, RNE rounding, canonical NaN.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic              sa, sb, sl, ss;
    logic [7:0]        ea, eb, el, es, d;
    logic [22:0]       fa, fb;
    logic [23:0]       ml, ms;
    logic [53:0]       w;
    logic [26:0]       al, as, m;
    logic [27:0]       sum;
    logic signed [9:0] e;
    logic [9:0]        lz;
    logic              found, inc;
    logic [24:0]       mr;
    logic [31:0]       r;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    sl = 1'b0; ss = 1'b0; el = 8'h0; es = 8'h0; ml = 24'h0; ms = 24'h0;
    d = 8'h0; w = 54'h0; al = 27'h0; as = 27'h0; m = 27'h0; sum = 28'h0;
    e = 10'sd0; lz = 10'd0; found = 1'b0; inc = 1'b0; mr = 25'h0;
    r = 32'h0;
    if ((ea == 8'hFF && fa != 23'h0) || (eb == 8'hFF && fb != 23'h0)) begin
      r = CNAN;
    end else if (ea == 8'hFF && eb == 8'hFF) begin
      r = (sa == sb) ? {sa, 8'hFF, 23'h0} : CNAN;
    end else if (ea == 8'hFF) begin
      r = {sa, 8'hFF, 23'h0};
    end else if (eb == 8'hFF) begin
      r = {sb, 8'hFF, 23'h0};
    end else if (ea == 8'h0 && eb == 8'h0) begin
      // Both zero (denormals count as zero): only -0 + -0 keeps the minus sign.
      r = {sa & sb, 31'h0};
    end else if (ea == 8'h0) begin
      r = b;
    end else if (eb == 8'h0) begin
      r = a;
    end else begin
      // Larger magnitude goes first so the magnitude subtraction never goes negative.
      if ({ea, fa} >= {eb, fb}) begin
        sl = sa; el = ea; ml = {1'b1, fa};
        ss = sb; es = eb; ms = {1'b1, fb};
      end else begin
        sl = sb; el = eb; ml = {1'b1, fb};
        ss = sa; es = ea; ms = {1'b1, fa};
      end
      d = el - es;
      if (d > 8'd27) d = 8'd27;
      // Top 27 bits are the aligned operand with guard/round; everything below folds into sticky.
      w  = {ms, 3'b000, 27'h0} >> d;
      al = {ml, 3'b000};
      as = {w[53:28], w[27] | (|w[26:0])};
      e  = $signed({2'b00, el});
      if (sl == ss) begin
        sum = {1'b0, al} + {1'b0, as};
        if (sum[27]) begin
          m = {sum[27:2], sum[1] | sum[0]};
          e = e + 10'sd1;
        end else begin
          m = sum[26:0];
        end
      end else begin
        sum = {1'b0, al} - {1'b0, as};
        m   = sum[26:0];
        for (int i = 26; i >= 0; i--) begin
          if (!found) begin
            if (m[i]) found = 1'b1;
            else      lz = lz + 10'd1;
          end
        end
        m = m << lz;
        e = e - $signed(lz);
      end
      if (sl != ss && sum == 28'h0) begin
        r = 32'h0;
      end else if (e <= 10'sd0) begin
        r = {sl, 31'h0};
      end else begin
        inc = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[26:3]} + {24'h0, inc};
        if (mr[24]) begin
          e  = e + 10'sd1;
          mr = mr >> 1;
        end
        if (e >= 10'sd255) r = {sl, 8'hFF, 23'h0};
        else               r = {sl, e[7:0], mr[22:0]};
      end
    end
    return r;
  endfunction

  assign w_hs      = in_valid & r_in_ready;
  assign w_cnt_nxt = r_cnt + LEN_W'(1);
  assign w_sum     = fadd(r_acc, in_z);

  // Control FSM: IDLE -> ACC (collect len terms) -> DONE (hold result until taken).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= 32'h0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_z     <= 32'h0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= 32'h0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_len_q    <= len;
              r_in_ready <= 1'b1;
              r_state    <= S_ACC;
            end else begin
              r_out_z     <= 32'h0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_ACC: begin
          if (w_hs) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len_q) begin
              r_out_z     <= w_sum;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dp_acc.sv
// tb/tb_dp_acc.sv - scoreboard testbench for dp_acc
module tb_dp_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_z = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_z;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int irdy_cycles = 0;
  logic [31:0] sb[$];

  dp_acc #(.LEN_W(16), .CNAN(32'h7FC0_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Monitor: pop the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n && in_ready) irdy_cycles++;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", out_z, 32'hxxxxxxxx);
      end else begin
        chk("sb_out_z", out_z, sb.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    cyc();
    start = 1'b0;
    len   = 16'hBEEF;
  endtask

  task automatic feed(input logic [31:0] z, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_z     = z;
    while (!in_ready && t < 50) begin
      cyc();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    cyc();
    in_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 50) begin
      cyc();
      t++;
    end
    if (busy) chk("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    sb.push_back(exp);
    do_start(16'd2);
    feed(a, 0);
    feed(b, 0);
    wait_idle();
  endtask

  task automatic run1(input logic [31:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    do_start(16'd1);
    feed(a, 0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_z", out_z, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // 1+1+1+1 back-to-back
    irdy_cycles = 0;
    sb.push_back(32'h4080_0000);
    do_start(16'd4);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 4; i++) feed(32'h3F80_0000, 0);
    chk("t1_out_valid_latency", {31'h0, out_valid}, 32'h1);
    cyc();
    chk("t1_busy_fall", {31'h0, busy}, 32'h0);
    chk("t1_in_ready_cycles", irdy_cycles, 32'd4);

    // Cancellation and signed zeros
    run2(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    run1(32'h8000_0000, 32'h0000_0000);

    // Round-to-nearest-even ties
    run2(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000);
    run2(32'h4B80_0000, 32'h4040_0000, 32'h4B80_0002);

    // Specials
    run2(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    run2(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run1(32'h0000_0001, 32'h0000_0000);
    run2(32'h7FA0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run2(32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000);

    // len=3 with gaps, plus start pulse in ACC that must be ignored
    sb.push_back(32'h4040_0000);
    do_start(16'd3);
    feed(32'h3F80_0000, 2);
    start = 1'b1;
    len   = 16'd0;
    cyc();
    start = 1'b0;
    feed(32'h3F80_0000, 3);
    feed(32'h3F80_0000, 1);
    wait_idle();

    // out_ready low for 5 cycles; start pulse in DONE ignored
    out_ready = 1'b0;
    sb.push_back(32'h40A0_0000);
    do_start(16'd2);
    feed(32'h4000_0000, 0);
    feed(32'h4040_0000, 0);
    start = 1'b1;
    len   = 16'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_out_z", out_z, 32'h40A0_0000);
      #1;
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    cyc();
    chk("no_second_output", {31'h0, out_valid}, 32'h0);

    // len=0
    sb.push_back(32'h0000_0000);
    do_start(16'd0);
    chk("len0_out_valid", {31'h0, out_valid}, 32'h1);
    chk("len0_out_z", out_z, 32'h0);
    wait_idle();

    // start together with in_valid in IDLE: the term must not be consumed
    in_valid = 1'b1;
    in_z     = 32'h4000_0000;
    run1(32'h3F80_0000, 32'h3F80_0000);

    // Reset mid-accumulation
    do_start(16'd4);
    feed(32'h3F80_0000, 0);
    feed(32'h3F80_0000, 0);
    in_valid = 1'b1;
    in_z     = 32'h3F80_0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_out_z", out_z, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    run2(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);

    repeat (3) cyc();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dp_acc.md
Name: dp_acc

Overview:
- Sequential FP32 accumulator directly downstream of the combinational dot-product unit.
- Consumes one dot-product result `z` per handshake and sums a programmed number of them into a single FP32 total.
- Presents the total on a valid/ready output.
- Used to build long dot products out of 4-element DP chunks.

Parameters:
- LEN_W, 16, width of the term-count field; max terms = 2^LEN_W-1
- CNAN, 32'h7FC00000, canonical NaN emitted for any NaN result

Ports:
- clk      input   1       single clock, rising edge
- rst_n    input   1       asynchronous active-low reset
- start    input   1       begin new accumulation (sampled in IDLE only)
- len      input   LEN_W   number of terms to sum, sampled with start
- in_valid input   1       upstream DP result valid
- in_ready output  1       accumulator accepts in_z this cycle
- in_z     input   32      FP32 term (DP output z)
- out_valid output 1       final sum available
- out_ready input  1       downstream accepts out_z
- out_z    output  32      FP32 accumulated sum
- busy     output  1       high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, acc=0x00000000, cnt=0, len_q=0, in_ready=0, out_valid=0, out_z=0, busy=0.
- Reset asserted mid-operation aborts the sum; no output is produced.
- States:
  - IDLE -> ACC on start with len!=0: latch len_q=len, acc=+0, cnt=0.
  - IDLE -> DONE on start with len==0: out_z=+0.
  - ACC -> DONE when the handshake that makes cnt==len_q completes.
  - DONE -> IDLE on out_valid&&out_ready.
- start is ignored outside IDLE; len is ignored without start.
- in_ready=1 only in ACC. Term handshake = in_valid&&in_ready: acc<=fadd(acc,in_z), cnt<=cnt+1. Maximum rate is 1 term/cycle.
- in_valid low in ACC: hold acc and cnt, no timeout.
- out_valid=1 only in DONE. out_z=acc is registered and held stable while out_ready=0.
- Latency:
  - out_valid rises the cycle after the last term handshake.
  - For len==0, out_valid rises the cycle after start.
- fadd rules, single-cycle combinational, IEEE-754 binary32:
  - Align smaller exponent with guard/round/sticky; add or subtract magnitudes; normalise with leading-zero count; round-to-nearest-even.
  - Denormal input (exp=0, frac!=0) is treated as a signed zero (FTZ).
  - Result below the min normal flushes to a zero carrying the result sign.
  - Exact cancellation (x + -x) gives +0. +0 + -0 = +0. -0 + -0 = -0.
  - Rounding carry out of the mantissa increments the exponent. Exponent >=255 after rounding gives signed Inf (0x7F800000/0xFF800000).
  - Inf + finite = that Inf. Inf + same-sign Inf = Inf.
  - Inf + opposite Inf, or any NaN operand, gives CNAN. A NaN acc stays CNAN for the remaining terms.
- Because acc starts at +0, a single term of -0 yields +0.
- cnt and len_q are LEN_W bits wide; cnt never wraps because ACC exits at cnt==len_q.
- Simultaneous start and in_valid in IDLE: start is taken, and in_z is not consumed (in_ready=0 that cycle).

Test Plan:
- start len=4; feed 0x3F800000 four times back-to-back -> in_ready high 4 cycles, out_valid next cycle, out_z=0x40800000, busy falls after out_ready.
- len=2; feed 0x3F800000 then 0xBF800000 -> out_z=0x00000000. Separately, len=1 with 0x80000000 -> out_z=0x00000000.
- RNE tie:
  - len=2, 0x4B800000 then 0x3F800000 -> out_z=0x4B800000.
  - len=2, 0x4B800000 then 0x40400000 -> out_z=0x4B800002.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x00000001 (denormal) alone -> 0x00000000.
- Handshake:
  - len=3 with in_valid gaps -> same sum as back-to-back.
  - out_ready held low 5 cycles -> out_valid and out_z stable.
  - start pulses during ACC/DONE are ignored.
- len=0 start -> out_valid=1, out_z=0 one cycle later. rst_n low mid-ACC (after 2 of 4 terms) -> all outputs 0 immediately, IDLE, next start works normally.
